// File: rtl/msrh_lsu_pkg.sv
// msrh_lsu_pkg: L2 request command/source types, widths and the round-robin step helper
package msrh_lsu_pkg;
    localparam int PADDR_W       = 40;
    localparam int ICACHE_DATA_W = 64;
    localparam int L2_CMD_TAG_W  = 4;
    localparam int L2_SRC_W      = 2;
    localparam int L2_ARB_TAG_W  = L2_CMD_TAG_W + L2_SRC_W;

    typedef enum logic [1:0] {
        M_XRD = 2'd0,
        M_XWR = 2'd1,
        M_PFR = 2'd2,
        M_NOP = 2'd3
    } mem_cmd_t;

    typedef enum logic [L2_SRC_W-1:0] {
        SRC_IC  = 2'd0,
        SRC_L1D = 2'd1,
        SRC_PTW = 2'd2
    } l2_src_t;

    // Advance a requester index modulo 3.
    function automatic logic [1:0] rr_inc3(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction
endpackage

// File: rtl/msrh_rr_arbiter3.sv
// msrh_rr_arbiter3: three-way round-robin pick starting at ptr; one-hot grant and pointer after the winner
module msrh_rr_arbiter3
    import msrh_lsu_pkg::*;
(
    input  logic [1:0] ptr,
    input  logic [2:0] valid,
    output logic [2:0] grant,
    output logic [1:0] next_ptr
);
    logic [3:0] v;
    logic [1:0] c1;
    logic [1:0] c2;
    logic [1:0] win;
    logic       any;

    // Search ptr, ptr+1, ptr+2; the padded bit keeps every index in range.
    always_comb begin
        v        = {1'b0, valid};
        c1       = rr_inc3(ptr);
        c2       = rr_inc3(c1);
        win      = v[ptr] ? ptr : v[c1] ? c1 : c2;
        any      = |valid;
        grant    = {3{any}} & 3'(4'd1 << win);
        next_ptr = any ? rr_inc3(win) : ptr;
    end
endmodule

// File: rtl/msrh_l2_req_arbiter.sv
// msrh_l2_req_arbiter: merges IC/L1D/PTW L2 requests round-robin and routes responses by source tag; MSRH_L2_ARB_PERF_CNT_EN adds grant/stall counters
module msrh_l2_req_arbiter
    import msrh_lsu_pkg::*;
#(
    parameter int TAG_W  = msrh_lsu_pkg::L2_CMD_TAG_W,
    parameter int ADDR_W = msrh_lsu_pkg::PADDR_W,
    parameter int DATA_W = msrh_lsu_pkg::ICACHE_DATA_W,
    parameter int SRC_W  = 2
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_ic_req_valid,
    input  mem_cmd_t               i_ic_req_cmd,
    input  logic [ADDR_W-1:0]      i_ic_req_addr,
    input  logic [TAG_W-1:0]       i_ic_req_tag,
    input  logic [DATA_W-1:0]      i_ic_req_data,
    input  logic [DATA_W/8-1:0]    i_ic_req_byte_en,
    output logic                   o_ic_req_ready,
    input  logic                   i_l1d_req_valid,
    input  mem_cmd_t               i_l1d_req_cmd,
    input  logic [ADDR_W-1:0]      i_l1d_req_addr,
    input  logic [TAG_W-1:0]       i_l1d_req_tag,
    input  logic [DATA_W-1:0]      i_l1d_req_data,
    input  logic [DATA_W/8-1:0]    i_l1d_req_byte_en,
    output logic                   o_l1d_req_ready,
    input  logic                   i_ptw_req_valid,
    input  mem_cmd_t               i_ptw_req_cmd,
    input  logic [ADDR_W-1:0]      i_ptw_req_addr,
    input  logic [TAG_W-1:0]       i_ptw_req_tag,
    input  logic [DATA_W-1:0]      i_ptw_req_data,
    input  logic [DATA_W/8-1:0]    i_ptw_req_byte_en,
    output logic                   o_ptw_req_ready,
    output logic                   o_l2_req_valid,
    output mem_cmd_t               o_l2_req_cmd,
    output logic [ADDR_W-1:0]      o_l2_req_addr,
    output logic [TAG_W+SRC_W-1:0] o_l2_req_tag,
    output logic [DATA_W-1:0]      o_l2_req_data,
    output logic [DATA_W/8-1:0]    o_l2_req_byte_en,
    input  logic                   i_l2_req_ready,
    input  logic                   i_l2_resp_valid,
    input  logic [TAG_W+SRC_W-1:0] i_l2_resp_tag,
    input  logic [DATA_W-1:0]      i_l2_resp_data,
    output logic                   o_l2_resp_ready,
    output logic                   o_ic_resp_valid,
    output logic [TAG_W-1:0]       o_ic_resp_tag,
    output logic [DATA_W-1:0]      o_ic_resp_data,
    input  logic                   i_ic_resp_ready,
    output logic                   o_l1d_resp_valid,
    output logic [TAG_W-1:0]       o_l1d_resp_tag,
    output logic [DATA_W-1:0]      o_l1d_resp_data,
    input  logic                   i_l1d_resp_ready,
    output logic                   o_ptw_resp_valid,
    output logic [TAG_W-1:0]       o_ptw_resp_tag,
    output logic [DATA_W-1:0]      o_ptw_resp_data,
    input  logic                   i_ptw_resp_ready,
    output logic                   o_resp_err
`ifdef MSRH_L2_ARB_PERF_CNT_EN
    ,
    output logic [31:0]            o_perf_grant_cnt [3],
    output logic [31:0]            o_perf_stall_cnt
`endif
);
    logic [2:0]          req_v;
    logic [2:0]          grant;
    logic [1:0]          ptr;
    logic [1:0]          next_ptr;
    logic                load_en;
    l2_src_t             win_src;
    mem_cmd_t            sel_cmd;
    logic [ADDR_W-1:0]   sel_addr;
    logic [TAG_W-1:0]    sel_tag;
    logic [DATA_W-1:0]   sel_data;
    logic [DATA_W/8-1:0] sel_be;

    logic                rbuf_valid;
    logic [SRC_W-1:0]    rbuf_src;
    logic [TAG_W-1:0]    rbuf_tag;
    logic [DATA_W-1:0]   rbuf_data;
    logic [SRC_W-1:0]    resp_src;
    logic                dest_ready;
    logic                resp_accept;
    logic                resp_illegal;

    assign req_v   = {i_ptw_req_valid, i_l1d_req_valid, i_ic_req_valid};
    assign load_en = !o_l2_req_valid | i_l2_req_ready;

    msrh_rr_arbiter3 u_rr (
        .ptr      (ptr),
        .valid    (req_v),
        .grant    (grant),
        .next_ptr (next_ptr)
    );

    assign o_ic_req_ready  = load_en & grant[0];
    assign o_l1d_req_ready = load_en & grant[1];
    assign o_ptw_req_ready = load_en & grant[2];

    // Select the winning requester's payload.
    always_comb begin
        win_src  = grant[2] ? SRC_PTW : grant[1] ? SRC_L1D : SRC_IC;
        sel_cmd  = grant[2] ? i_ptw_req_cmd     : grant[1] ? i_l1d_req_cmd     : i_ic_req_cmd;
        sel_addr = grant[2] ? i_ptw_req_addr    : grant[1] ? i_l1d_req_addr    : i_ic_req_addr;
        sel_tag  = grant[2] ? i_ptw_req_tag     : grant[1] ? i_l1d_req_tag     : i_ic_req_tag;
        sel_data = grant[2] ? i_ptw_req_data    : grant[1] ? i_l1d_req_data    : i_ic_req_data;
        sel_be   = grant[2] ? i_ptw_req_byte_en : grant[1] ? i_l1d_req_byte_en : i_ic_req_byte_en;
    end

    // Output valid and round-robin pointer; both move only when the slot can take a new request.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_l2_req_valid <= 1'b0;
            ptr            <= 2'd0;
        end else if (load_en) begin
            o_l2_req_valid <= |req_v;
            ptr            <= next_ptr;
        end
    end

    // Request payload capture; contents are meaningless while valid is low.
    always_ff @(posedge i_clk) begin
        if (load_en && |req_v) begin
            o_l2_req_cmd     <= sel_cmd;
            o_l2_req_addr    <= sel_addr;
            o_l2_req_tag     <= {win_src, sel_tag};
            o_l2_req_data    <= sel_data;
            o_l2_req_byte_en <= sel_be;
        end
    end

    assign resp_src        = i_l2_resp_tag[TAG_W +: SRC_W];
    assign resp_illegal    = resp_src == 2'd3;
    assign dest_ready      = (rbuf_src == SRC_PTW) ? i_ptw_resp_ready :
                             (rbuf_src == SRC_L1D) ? i_l1d_resp_ready : i_ic_resp_ready;
    assign o_l2_resp_ready = !rbuf_valid | dest_ready;
    assign resp_accept     = i_l2_resp_valid & o_l2_resp_ready;

    // Response entry occupancy and the sticky illegal-source flag.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rbuf_valid <= 1'b0;
            o_resp_err <= 1'b0;
        end else begin
            if (resp_accept && !resp_illegal)
                rbuf_valid <= 1'b1;
            else if (dest_ready)
                rbuf_valid <= 1'b0;
            if (resp_accept && resp_illegal)
                o_resp_err <= 1'b1;
        end
    end

    // Response payload capture for legal sources.
    always_ff @(posedge i_clk) begin
        if (resp_accept && !resp_illegal) begin
            rbuf_src  <= resp_src;
            rbuf_tag  <= i_l2_resp_tag[TAG_W-1:0];
            rbuf_data <= i_l2_resp_data;
        end
    end

    assign o_ic_resp_valid  = rbuf_valid & (rbuf_src == SRC_IC);
    assign o_l1d_resp_valid = rbuf_valid & (rbuf_src == SRC_L1D);
    assign o_ptw_resp_valid = rbuf_valid & (rbuf_src == SRC_PTW);
    assign o_ic_resp_tag    = rbuf_tag;
    assign o_l1d_resp_tag   = rbuf_tag;
    assign o_ptw_resp_tag   = rbuf_tag;
    assign o_ic_resp_data   = rbuf_data;
    assign o_l1d_resp_data  = rbuf_data;
    assign o_ptw_resp_data  = rbuf_data;

`ifdef MSRH_L2_ARB_PERF_CNT_EN
    // Per-source grant counters and downstream stall counter, free-running with wrap.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < 3; i++)
                o_perf_grant_cnt[i] <= 32'd0;
            o_perf_stall_cnt <= 32'd0;
        end else begin
            for (int i = 0; i < 3; i++)
                if (load_en && grant[i])
                    o_perf_grant_cnt[i] <= o_perf_grant_cnt[i] + 32'd1;
            if (o_l2_req_valid && !i_l2_req_ready)
                o_perf_stall_cnt <= o_perf_stall_cnt + 32'd1;
        end
    end
`endif
endmodule
